// File: rtl/axi_read_arbiter_if.sv
// Bundle of the two client read ports and the shared AXI3 HP read master port.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface axi_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] s0_araddr;
  logic              s0_arvalid;
  logic              s0_arready;
  logic [DATA_W-1:0] s0_rdata;
  logic              s0_rvalid;
  logic              s0_rready;
  logic              s0_rlast;

  logic [ADDR_W-1:0] s1_araddr;
  logic              s1_arvalid;
  logic              s1_arready;
  logic [DATA_W-1:0] s1_rdata;
  logic              s1_rvalid;
  logic              s1_rready;
  logic              s1_rlast;

  logic [ADDR_W-1:0] M_AXI_ARADDR;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY;
  logic [3:0]        M_AXI_ARLEN;
  logic [1:0]        M_AXI_ARSIZE;
  logic [1:0]        M_AXI_ARBURST;
  logic [DATA_W-1:0] M_AXI_RDATA;
  logic              M_AXI_RVALID;
  logic              M_AXI_RREADY;
  logic              M_AXI_RLAST;
  logic [1:0]        M_AXI_RRESP;

  modport master (
    input  s0_araddr, s0_arvalid, s0_rready,
    output s0_arready, s0_rdata, s0_rvalid, s0_rlast,
    input  s1_araddr, s1_arvalid, s1_rready,
    output s1_arready, s1_rdata, s1_rvalid, s1_rlast,
    output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RVALID, M_AXI_RLAST, M_AXI_RRESP,
    output M_AXI_RREADY
  );

  modport slave (
    output s0_araddr, s0_arvalid, s0_rready,
    input  s0_arready, s0_rdata, s0_rvalid, s0_rlast,
    output s1_araddr, s1_arvalid, s1_rready,
    input  s1_arready, s1_rdata, s1_rvalid, s1_rlast,
    input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RVALID, M_AXI_RLAST, M_AXI_RRESP,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI3 HP read port between two burst clients.
// Optional AXI_RD_ARB_ERR_EN adds err_sticky/err_count for bad responses and RLAST/count mismatches.
module axi_read_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int BURST_BEATS = 16
) (
  input  logic               ACLK,
  input  logic               rst,
  axi_read_arbiter_if.master bus,
  output logic               busy,
  output logic               owner
`ifdef AXI_RD_ARB_ERR_EN
  ,
  output logic               err_sticky,
  output logic [15:0]        err_count
`endif
);

  localparam int CNT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_BEATS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]        state;
  logic              rr_ptr;
  logic [CNT_W-1:0]  beat_cnt;

  logic              gnt_valid;
  logic              gnt_idx;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] rdata_bcast;
  logic              in_data;
  logic              rready_sel;
  logic              beat;

  // Grant is only meaningful in IDLE; with both requesting, rr_ptr breaks the tie.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    if (state == S_IDLE) begin
      gnt_valid = bus.s0_arvalid | bus.s1_arvalid;
      gnt_idx   = (bus.s0_arvalid && bus.s1_arvalid) ? rr_ptr : bus.s1_arvalid;
    end
  end

  assign gnt_addr = gnt_idx ? bus.s1_araddr : bus.s0_araddr;

  assign bus.s0_arready = gnt_valid && !gnt_idx;
  assign bus.s1_arready = gnt_valid &&  gnt_idx;

  assign bus.M_AXI_ARVALID = (state == S_ADDR);
  assign bus.M_AXI_ARLEN   = 4'(BURST_BEATS - 1);
  assign bus.M_AXI_ARSIZE  = 2'b11;
  assign bus.M_AXI_ARBURST = 2'b01;

  assign in_data    = (state == S_DATA);
  assign rready_sel = owner ? bus.s1_rready : bus.s0_rready;
  assign bus.M_AXI_RREADY = in_data && rready_sel;
  assign beat       = in_data && bus.M_AXI_RVALID && rready_sel;

  assign rdata_bcast  = bus.M_AXI_RDATA;
  assign bus.s0_rdata = rdata_bcast;
  assign bus.s1_rdata = rdata_bcast;

  assign bus.s0_rvalid = in_data && !owner && bus.M_AXI_RVALID;
  assign bus.s1_rvalid = in_data &&  owner && bus.M_AXI_RVALID;
  assign bus.s0_rlast  = in_data && !owner && bus.M_AXI_RLAST;
  assign bus.s1_rlast  = in_data &&  owner && bus.M_AXI_RLAST;

  assign busy = (state != S_IDLE);

  // RLAST alone ends the burst; beat_cnt parks at zero if the slave overruns the length.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (rst) begin
      state            <= S_IDLE;
      rr_ptr           <= 1'b0;
      owner            <= 1'b0;
      bus.M_AXI_ARADDR <= '0;
      beat_cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            bus.M_AXI_ARADDR <= gnt_addr;
            owner            <= gnt_idx;
            rr_ptr           <= ~gnt_idx;
            state            <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus.M_AXI_ARREADY) begin
            beat_cnt <= LAST_CNT;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat) begin
            if (beat_cnt != '0) beat_cnt <= beat_cnt - 1'b1;
            if (bus.M_AXI_RLAST) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AXI_RD_ARB_ERR_EN
  logic err_evt;

  // A mismatch is RLAST arriving off-count, or the counted last beat arriving without RLAST.
  assign err_evt = beat && ((bus.M_AXI_RRESP != 2'b00) ||
                            (bus.M_AXI_RLAST != (beat_cnt == '0)));

  always_ff @(posedge ACLK) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (err_evt) begin
      err_sticky <= 1'b1;
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^bus.M_AXI_RRESP;
`endif

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: AR timing, hold, round-robin, R steering, reset mid-burst.
// Build with AXI_RD_ARB_ERR_EN defined to also exercise the error counters.
module tb_axi_read_arbiter;

  logic        ACLK = 1'b0;
  logic        rst;
  logic        busy;
  logic        owner;
`ifdef AXI_RD_ARB_ERR_EN
  logic        err_sticky;
  logic [15:0] err_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  axi_read_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  axi_read_arbiter #(.ADDR_W(32), .DATA_W(64), .BURST_BEATS(16)) dut (
    .ACLK  (ACLK),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
`ifdef AXI_RD_ARB_ERR_EN
    ,
    .err_sticky (err_sticky),
    .err_count  (err_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave side of the R channel: present beats, follow the owner's rready, optionally reset on one beat.
  task automatic run_data(input bit own, input int nbeats, input bit toggle,
                          input int err_beat, input logic [63:0] base, input int rst_beat);
    int  i   = 0;
    int  cyc = 0;
    bit  rr  = 1'b1;
    while (i < nbeats && cyc < 200) begin
      bus.M_AXI_RVALID = 1'b1;
      bus.M_AXI_RDATA  = base + 64'(i);
      bus.M_AXI_RLAST  = (i == nbeats - 1);
      bus.M_AXI_RRESP  = (i == err_beat) ? 2'b10 : 2'b00;
      if (own) bus.s1_rready = rr; else bus.s0_rready = rr;
      if (i == rst_beat) rst = 1'b1;
      @(negedge ACLK);
      check("rready_follow", bus.M_AXI_RREADY, rr);
      check("own_rvalid",   own ? bus.s1_rvalid : bus.s0_rvalid, 1);
      check("other_rvalid", own ? bus.s0_rvalid : bus.s1_rvalid, 0);
      check("own_rdata",    own ? bus.s1_rdata  : bus.s0_rdata,  base + 64'(i));
      check("own_rlast",    own ? bus.s1_rlast  : bus.s0_rlast,  (i == nbeats - 1));
      check("no_ack_busy",  bus.s0_arready | bus.s1_arready, 0);
      @(posedge ACLK); #1;
      cyc++;
      if (i == rst_beat) break;
      if (rr) i++;
      if (toggle) rr = !rr;
    end
    check("beats_done", i, (rst_beat >= 0) ? rst_beat : nbeats);
    bus.M_AXI_RVALID = 1'b0;
    bus.M_AXI_RLAST  = 1'b0;
    bus.M_AXI_RRESP  = 2'b00;
    bus.s0_rready    = 1'b0;
    bus.s1_rready    = 1'b0;
  endtask

  // Called at posedge+1 with the state in IDLE and the client request(s) already driven.
  task automatic grant_burst(input bit idx, input logic [31:0] exp_addr, input bit keep,
                             input int nbeats, input bit toggle, input int err_beat, input int rst_beat);
    @(negedge ACLK);
    check("idle_busy",     busy, 0);
    check("arready_gnt",   idx ? bus.s1_arready : bus.s0_arready, 1);
    check("arready_other", idx ? bus.s0_arready : bus.s1_arready, 0);
    @(posedge ACLK); #1;
    if (keep) begin
      if (idx) bus.s1_araddr += 32'h80; else bus.s0_araddr += 32'h80;
    end else begin
      if (idx) bus.s1_arvalid = 1'b0; else bus.s0_arvalid = 1'b0;
    end
    bus.M_AXI_ARREADY = 1'b1;
    @(negedge ACLK);
    check("addr_arvalid", bus.M_AXI_ARVALID, 1);
    check("addr_araddr",  bus.M_AXI_ARADDR, exp_addr);
    check("addr_owner",   owner, idx);
    check("addr_busy",    busy, 1);
    check("addr_no_ack",  bus.s0_arready | bus.s1_arready, 0);
    @(posedge ACLK); #1;
    bus.M_AXI_ARREADY = 1'b0;
    run_data(idx, nbeats, toggle, err_beat, {32'hD0, exp_addr}, rst_beat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.s0_araddr = '0; bus.s0_arvalid = 1'b0; bus.s0_rready = 1'b0;
    bus.s1_araddr = '0; bus.s1_arvalid = 1'b0; bus.s1_rready = 1'b0;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RDATA = '0; bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RLAST = 1'b0; bus.M_AXI_RRESP = 2'b00;

    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_busy",    busy, 0);
    check("rst_owner",   owner, 0);
    check("rst_arvalid", bus.M_AXI_ARVALID, 0);
    check("rst_araddr",  bus.M_AXI_ARADDR, 0);
    check("rst_rready",  bus.M_AXI_RREADY, 0);
    check("rst_rvalid",  bus.s0_rvalid | bus.s1_rvalid, 0);
    check("rst_rlast",   bus.s0_rlast | bus.s1_rlast, 0);
`ifdef AXI_RD_ARB_ERR_EN
    check("rst_err_sticky", err_sticky, 0);
    check("rst_err_count",  err_count, 0);
`endif
    @(posedge ACLK); #1;
    rst = 1'b0;

    // Client 0 alone; ARREADY withheld for 5 ADDR cycles while a stray RVALID is present.
    bus.s0_araddr  = 32'h1000;
    bus.s0_arvalid = 1'b1;
    @(negedge ACLK);
    check("a_s0_arready_t",  bus.s0_arready, 1);
    check("a_s1_arready_t",  bus.s1_arready, 0);
    check("a_arvalid_t",     bus.M_AXI_ARVALID, 0);
    @(posedge ACLK); #1;
    bus.s0_arvalid   = 1'b0;
    bus.s0_araddr    = 32'h0;
    bus.M_AXI_RVALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      check("a_hold_arvalid", bus.M_AXI_ARVALID, 1);
      check("a_hold_araddr",  bus.M_AXI_ARADDR, 32'h1000);
      check("a_stray_rready", bus.M_AXI_RREADY, 0);
      check("a_stray_rvalid", bus.s0_rvalid, 0);
      @(posedge ACLK); #1;
    end
    check("a_arlen",   bus.M_AXI_ARLEN, 4'hF);
    check("a_arsize",  bus.M_AXI_ARSIZE, 2'b11);
    check("a_arburst", bus.M_AXI_ARBURST, 2'b01);
    bus.M_AXI_RVALID  = 1'b0;
    bus.M_AXI_ARREADY = 1'b1;
    @(negedge ACLK);
    check("a_hs_arvalid", bus.M_AXI_ARVALID, 1);
    @(posedge ACLK); #1;
    bus.M_AXI_ARREADY = 1'b0;
    @(negedge ACLK);
    check("a_post_arvalid", bus.M_AXI_ARVALID, 0);
    check("a_post_busy",    busy, 1);
    @(posedge ACLK); #1;
    run_data(1'b0, 16, 1'b0, -1, 64'hA000, -1);
    @(negedge ACLK);
    check("a_end_busy", busy, 0);
    @(posedge ACLK); #1;

    // Client 1 alone with rready toggling 1,0.
    bus.s1_araddr  = 32'h2000;
    bus.s1_arvalid = 1'b1;
    grant_burst(1'b1, 32'h2000, 1'b0, 16, 1'b1, -1, -1);

    // Both clients requesting back to back; reset lands on beat 7 of the last (client 1) burst.
    bus.s0_araddr = 32'h3000; bus.s0_arvalid = 1'b1;
    bus.s1_araddr = 32'h5000; bus.s1_arvalid = 1'b1;
    grant_burst(1'b0, 32'h3000, 1'b1, 16, 1'b0, -1, -1);
    grant_burst(1'b1, 32'h5000, 1'b1, 16, 1'b0, -1, -1);
    grant_burst(1'b0, 32'h3080, 1'b1, 16, 1'b0, -1, -1);
    grant_burst(1'b1, 32'h5080, 1'b1, 16, 1'b0, -1, 6);
    rst = 1'b0;
    bus.M_AXI_RVALID = 1'b1;
    bus.s1_rready    = 1'b1;
    @(negedge ACLK);
    check("r_busy",       busy, 0);
    check("r_rready",     bus.M_AXI_RREADY, 0);
    check("r_arvalid",    bus.M_AXI_ARVALID, 0);
    check("r_owner",      owner, 0);
    check("r_s1_rvalid",  bus.s1_rvalid, 0);
    check("r_rr_ptr_s0",  bus.s0_arready, 1);
    check("r_rr_ptr_s1",  bus.s1_arready, 0);
    bus.s0_arvalid   = 1'b0;
    bus.s1_arvalid   = 1'b0;
    bus.M_AXI_RVALID = 1'b0;
    bus.s1_rready    = 1'b0;
    @(posedge ACLK); #1;

`ifdef AXI_RD_ARB_ERR_EN
    // SLVERR on beat 3, then a burst cut short by RLAST on beat 10.
    bus.s0_araddr = 32'h8000; bus.s0_arvalid = 1'b1;
    grant_burst(1'b0, 32'h8000, 1'b0, 16, 1'b0, 2, -1);
    @(negedge ACLK);
    check("e_sticky_1", err_sticky, 1);
    check("e_count_1",  err_count, 1);
    @(posedge ACLK); #1;
    bus.s0_araddr = 32'h8080; bus.s0_arvalid = 1'b1;
    grant_burst(1'b0, 32'h8080, 1'b0, 10, 1'b0, -1, -1);
    @(negedge ACLK);
    check("e_short_busy", busy, 0);
    check("e_sticky_2",   err_sticky, 1);
    check("e_count_2",    err_count, 2);
    @(posedge ACLK); #1;
`endif

    // Slave overruns: no RLAST on beat 16, so the burst must stay open until beat 17.
    bus.s0_araddr = 32'h9000; bus.s0_arvalid = 1'b1;
    grant_burst(1'b0, 32'h9000, 1'b0, 17, 1'b0, -1, -1);
    @(negedge ACLK);
    check("o_end_busy", busy, 0);
`ifdef AXI_RD_ARB_ERR_EN
    check("o_count", err_count, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
